// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD read custom instruction: FSM states and
// bit positions within the operand and result words.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EN_HIGH,
    EN_LOW,
    DONE
  } state_t;

  localparam int DATA_LSB    = 0;
  localparam int DATA_MSB    = 7;
  localparam int TIMEOUT_BIT = 8;
  localparam int OP_RS       = 0;
  localparam int OP_POLL     = 1;
  localparam int BUSY_BIT    = 7;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter shared by the setup, enable-high and enable-low phases.
// tc is high while the count sits at zero, i.e. on the last cycle of a phase.
module lcd_phase_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (en) begin
      if (load) begin
        count_reg <= load_val;
      end else if (count_reg != '0) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  assign tc = (count_reg == '0);

endmodule

// File: rtl/lcd_read_ctrl.sv
// HD44780 read-cycle custom instruction: status/address or data RAM read,
// with an optional busy-flag poll loop bounded by MAX_POLLS.
module lcd_read_ctrl
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC   = 3,
  parameter int EN_HIGH_CYC = 13,
  parameter int EN_LOW_CYC  = 13,
  parameter int MAX_POLLS   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] result,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  input  logic [7:0]  lcd_data_in,
  output logic        lcd_data_oe
);

  localparam int MAX_CYC = max3(SETUP_CYC, EN_HIGH_CYC, EN_LOW_CYC);
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam int PW      = $clog2(MAX_POLLS + 1);

  if (SETUP_CYC < 1 || EN_HIGH_CYC < 1 || EN_LOW_CYC < 1 || MAX_POLLS < 1) begin : g_bad_param
    $error("lcd_read_ctrl: cycle parameters and MAX_POLLS must be at least 1");
  end

  state_t                 state_reg, state_next;
  logic                   rs_reg, rs_next;
  logic                   poll_reg, poll_next;
  logic [PW-1:0]          poll_cnt_reg, poll_cnt_next;
  logic [DATA_MSB:DATA_LSB] data_reg, data_next;
  logic                   timeout_reg, timeout_next;
  logic                   done_reg, done_next;
  logic                   lcd_rs_reg, lcd_rs_next;
  logic                   lcd_rw_reg, lcd_rw_next;
  logic                   lcd_en_reg, lcd_en_next;
  logic                   lcd_oe_reg, lcd_oe_next;
  logic                   timer_load;
  logic [CW-1:0]          timer_val;
  logic                   timer_tc;
  logic                   busy;
  logic                   poll_again;
  logic                   unused_dataa;

  assign unused_dataa = ^dataa[31:2];
  assign busy         = data_reg[BUSY_BIT];
  assign poll_again   = poll_reg & busy & ((int'(poll_cnt_reg) + 1) < MAX_POLLS);

  lcd_phase_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .en       (clk_en),
    .load     (timer_load),
    .load_val (timer_val),
    .tc       (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      rs_reg       <= 1'b0;
      poll_reg     <= 1'b0;
      poll_cnt_reg <= '0;
      data_reg     <= '0;
      timeout_reg  <= 1'b0;
      done_reg     <= 1'b0;
      lcd_rs_reg   <= 1'b0;
      lcd_rw_reg   <= 1'b0;
      lcd_en_reg   <= 1'b0;
      lcd_oe_reg   <= 1'b1;
    end else if (clk_en) begin
      state_reg    <= state_next;
      rs_reg       <= rs_next;
      poll_reg     <= poll_next;
      poll_cnt_reg <= poll_cnt_next;
      data_reg     <= data_next;
      timeout_reg  <= timeout_next;
      done_reg     <= done_next;
      lcd_rs_reg   <= lcd_rs_next;
      lcd_rw_reg   <= lcd_rw_next;
      lcd_en_reg   <= lcd_en_next;
      lcd_oe_reg   <= lcd_oe_next;
    end
  end

  // Every state change reloads the timer with the length of the phase entered.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SETUP;
      SETUP:   if (timer_tc) state_next = EN_HIGH;
      EN_HIGH: if (timer_tc) state_next = EN_LOW;
      EN_LOW:  if (timer_tc) state_next = poll_again ? SETUP : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    timer_load = (state_next != state_reg);
    case (state_next)
      SETUP:   timer_val = CW'(SETUP_CYC - 1);
      EN_HIGH: timer_val = CW'(EN_HIGH_CYC - 1);
      EN_LOW:  timer_val = CW'(EN_LOW_CYC - 1);
      default: timer_val = '0;
    endcase
  end

  // Pins are decoded from the next state so they change on the same edge as the FSM.
  always_comb begin
    rs_next       = rs_reg;
    poll_next     = poll_reg;
    poll_cnt_next = poll_cnt_reg;
    data_next     = data_reg;
    timeout_next  = timeout_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          rs_next       = dataa[OP_RS];
          poll_next     = dataa[OP_POLL] & ~dataa[OP_RS];
          poll_cnt_next = '0;
          timeout_next  = 1'b0;
        end
      end
      EN_HIGH: begin
        if (timer_tc) data_next = lcd_data_in;
      end
      EN_LOW: begin
        if (timer_tc) begin
          if (poll_again) poll_cnt_next = poll_cnt_reg + 1'b1;
          else if (poll_reg & busy) timeout_next = 1'b1;
        end
      end
      default: ;
    endcase
    lcd_rw_next = (state_next == SETUP) || (state_next == EN_HIGH) || (state_next == EN_LOW);
    lcd_rs_next = lcd_rw_next & rs_next;
    lcd_en_next = (state_next == EN_HIGH);
    lcd_oe_next = ~lcd_rw_next;
    done_next   = (state_next == DONE);
  end

  always_comb begin
    result                    = '0;
    result[DATA_MSB:DATA_LSB] = data_reg;
    result[TIMEOUT_BIT]       = timeout_reg;
  end

  assign done        = done_reg;
  assign lcd_rs      = lcd_rs_reg;
  assign lcd_rw      = lcd_rw_reg;
  assign lcd_en      = lcd_en_reg;
  assign lcd_data_oe = lcd_oe_reg;

endmodule

// File: tb/tb_lcd_read_ctrl.sv
// Scoreboard bench for lcd_read_ctrl: stimulus pushes expected responses,
// a monitor measures each read cycle on the pins and compares at done.
module tb_lcd_read_ctrl;

  localparam int S  = 3;
  localparam int H  = 13;
  localparam int L  = 13;
  localparam int MP = 4;

  logic        clk = 1'b0;
  logic        reset, clk_en, start;
  logic [31:0] dataa;
  logic        done;
  logic [31:0] result;
  logic        lcd_rs, lcd_rw, lcd_en, lcd_data_oe;
  logic [7:0]  lcd_data_in;

  always #5 clk = ~clk;

  lcd_read_ctrl #(
    .SETUP_CYC(S), .EN_HIGH_CYC(H), .EN_LOW_CYC(L), .MAX_POLLS(MP)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .dataa(dataa),
    .done(done), .result(result), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_en(lcd_en), .lcd_data_in(lcd_data_in), .lcd_data_oe(lcd_data_oe)
  );

  typedef struct {
    logic [31:0] res;
    int          pulses;
    int          lat;
    int          high;
    logic        rs;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] bus_q[$];
  int checks = 0;
  int passes = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Reference: walk the bus bytes a read would see, one per E pulse.
  function automatic exp_t model(input logic [31:0] a, input int stall);
    exp_t       e;
    logic       poll;
    logic [7:0] b;
    int         n;
    poll = a[1] & ~a[0];
    n = 0;
    b = 8'h00;
    for (int i = 0; i < MP; i++) begin
      b = bus_q[i];
      n = i + 1;
      if (!poll || !b[7]) break;
    end
    e.res    = {23'b0, poll & b[7], b};
    e.pulses = n;
    e.lat    = n * (S + H + L) + stall;
    e.high   = n * H + stall;
    e.rs     = a[0];
    return e;
  endfunction

  task automatic load_bus(input logic [7:0] b0, b1, b2, b3);
    bus_q.delete();
    bus_q.push_back(b0); bus_q.push_back(b1); bus_q.push_back(b2); bus_q.push_back(b3);
  endtask

  task automatic issue(input logic [31:0] a, input int stall);
    exp_q.push_back(model(a, stall));
    $display("txn dataa=%h bus0=%h expect result=%h pulses=%0d", a, bus_q[0],
             exp_q[exp_q.size()-1].res, exp_q[exp_q.size()-1].pulses);
    dataa = a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dataa = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    exp_t e;
    logic active, en_prev, cur_rs;
    int   t, pulses, high, first_rise, viol;
    active = 1'b0; en_prev = 1'b0; cur_rs = 1'b0;
    t = 0; pulses = 0; high = 0; first_rise = -1; viol = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        active = 1'b0;
      end else if (active) begin
        t++;
        if (lcd_en && !en_prev) begin
          pulses++;
          if (pulses == 1) first_rise = t;
          if (bus_q.size() > 0) lcd_data_in = bus_q.pop_front();
          else lcd_data_in = 8'($urandom);
        end
        if (lcd_en) high++;
        if (done) begin
          done_cnt++;
          active = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_done", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("result", result, e.res);
            check("pulses", pulses, e.pulses);
            check("latency", t, e.lat);
            check("en_high_cycles", high, e.high);
            check("first_en_rise", first_rise, S);
            check("bus_dir_during_read", viol, 0);
            check("pins_at_done", {29'b0, lcd_rs, lcd_rw, lcd_data_oe}, 32'h1);
            $display("done result=%h pulses=%0d latency=%0d", result, pulses, t);
          end
        end else if (lcd_rw !== 1'b1 || lcd_data_oe !== 1'b0 || lcd_rs !== cur_rs) begin
          viol++;
        end
      end else begin
        if (done) begin
          done_cnt++;
          check("spurious_done", 32'(done), 32'(active));
        end
        if (start && clk_en) begin
          active = 1'b1; t = 0; pulses = 0; high = 0; first_rise = -1; viol = 0;
          cur_rs = (exp_q.size() > 0) ? exp_q[0].rs : 1'b0;
        end
      end
      en_prev = lcd_en;
    end
  end

  initial begin : stimulus
    int d0;
    logic [7:0] rb[4];
    reset = 1'b1; clk_en = 1'b1; start = 1'b0; dataa = '0; lcd_data_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_done", 32'(done), 0);
    check("reset_result", result, 0);
    check("reset_pins", {28'b0, lcd_rs, lcd_rw, lcd_en, lcd_data_oe}, 32'h1);
    @(negedge clk);

    load_bus(8'hA5, 8'h11, 8'h22, 8'h33); issue(32'h1, 0); wait_idle();
    load_bus(8'h8C, 8'h80, 8'h80, 8'h80); issue(32'h0, 0); wait_idle();
    load_bus(8'h80, 8'h80, 8'h80, 8'h05); issue(32'h2, 0); wait_idle();
    load_bus(8'hFF, 8'hFF, 8'hFF, 8'hFF); issue(32'h2, 0); wait_idle();
    load_bus(8'hC3, 8'hFF, 8'hFF, 8'hFF); issue(32'h3, 0); wait_idle();

    // clk_en stall in the middle of the enable pulse
    load_bus(8'h5A, 8'h00, 8'h00, 8'h00); issue(32'h1, 10);
    repeat (7) @(negedge clk);
    clk_en = 1'b0;
    repeat (10) @(negedge clk);
    clk_en = 1'b1;
    wait_idle();

    // a second start during an active read must be ignored
    d0 = done_cnt;
    load_bus(8'h3C, 8'h00, 8'h00, 8'h00); issue(32'h1, 0);
    repeat (10) @(negedge clk);
    dataa = 32'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
    check("single_done_for_restart", done_cnt - d0, 1);

    // reset during EN_LOW aborts without a done pulse
    d0 = done_cnt;
    load_bus(8'h77, 8'h00, 8'h00, 8'h00); issue(32'h0, 0);
    repeat (17) @(negedge clk);
    void'(exp_q.pop_back());
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_pins", {28'b0, lcd_rs, lcd_rw, lcd_en, lcd_data_oe}, 32'h1);
    check("abort_result", result, 0);
    repeat (40) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);

    // start while clk_en is low is ignored
    d0 = done_cnt;
    clk_en = 1'b0; dataa = 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; clk_en = 1'b1;
    repeat (40) @(negedge clk);
    check("gated_start_rw", 32'(lcd_rw), 0);
    check("gated_start_no_done", done_cnt - d0, 0);

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 4; i++) begin
        rb[i] = 8'($urandom);
        if ($urandom_range(0, 2) != 0) rb[i][7] = 1'b1;
      end
      load_bus(rb[0], rb[1], rb[2], rb[3]);
      issue(32'($urandom_range(0, 3)) | (32'($urandom) & 32'hFFFF_FFFC), 0);
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lcd_read_ctrl.md
Name: lcd_read_ctrl

Overview:
- Multi-cycle Nios II custom instruction that performs HD44780-style LCD **read** cycles (RW=1): busy-flag/address-counter read (RS=0) or data RAM read (RS=1).
- Returns the sampled byte to the CPU.
- Complements the write-only LCD custom instruction: the write path owns the bus while this block is idle, and releases it for the duration of a read.
- Optional busy-poll mode repeats status reads until the busy flag clears or a poll limit is reached.

Parameters:
- SETUP_CYC, 3, clocks from RS/RW valid to E rising (tAS ≥ 40 ns at 50 MHz).
- EN_HIGH_CYC, 13, clocks E held high; data sampled on the last of them (≥ 230 ns PW, tDDR 160 ns).
- EN_LOW_CYC, 13, clocks E low after the pulse before done or the next poll (tH plus tcycE ≥ 500 ns).
- MAX_POLLS, 255, maximum status reads in poll mode before the timeout flag is set.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clk_en  in  1  custom-instruction clock enable; when low, the FSM and all counters hold
- start  in  1  custom-instruction start, one-cycle pulse
- dataa  in  32  [0]=RS, [1]=poll mode (honoured only when RS=0), [31:2] ignored
- done  out  1  one-cycle completion pulse
- result  out  32  [7:0]=last sampled byte, [8]=poll timeout, [31:9]=0
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write (1=read)
- lcd_en  out  1  LCD enable strobe
- lcd_data_in  in  8  LCD DB[7:0] input path
- lcd_data_oe  out  1  1=FPGA drives DB (write path owns bus), 0=bus released for read

Behaviour:
- **Reset values:** state IDLE, done=0, result=0, lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_data_oe=1, counters=0.
- **Reset mid-operation:** abort at the same edge and return to IDLE with the reset values. lcd_en is low from the next cycle; no done pulse is produced.
- **clk_en=0:** state, counters and all outputs hold their values. start is ignored while clk_en=0.
- **States:** IDLE, SETUP, EN_HIGH, EN_LOW, DONE.
- **IDLE:** on start&clk_en:
  - latch rs_q=dataa[0] and poll_q=dataa[1]&~dataa[0];
  - clear poll count and timeout;
  - set lcd_rs=rs_q, lcd_rw=1, lcd_data_oe=0;
  - go to SETUP.
- **SETUP:** hold for SETUP_CYC cycles, then lcd_en=1 and go to EN_HIGH.
- **EN_HIGH:** hold for EN_HIGH_CYC cycles. On the final cycle's edge, capture lcd_data_in into result[7:0], set lcd_en=0 and go to EN_LOW.
- **EN_LOW:** hold for EN_LOW_CYC cycles with lcd_rs and lcd_rw unchanged. Then:
  - if poll_q, and the captured bit7 is 1, and poll count+1 < MAX_POLLS: increment poll count and go to SETUP (rs/rw stay set).
  - else if poll_q and bit7=1: set result[8]=1 and go to DONE.
  - else go to DONE.
- **DONE:** done=1 for exactly one cycle; lcd_rw=0, lcd_data_oe=1, lcd_rs=0. Next state is IDLE.
- **Latency (no poll, clk_en=1):** with start sampled at edge k, lcd_en is high for cycles k+S … k+S+H−1 and done is high in cycle k+S+H+L. Defaults give done 29 cycles after start.
- **Poll latency:** each additional poll adds S+H+L cycles.
- **start outside IDLE:** ignored, no queueing.
- **Operand handling:** dataa[1] with RS=1 is ignored, giving a single data read. result holds its value until the next completion; result[8] is cleared at start.
- **Counter width:** $clog2 of the largest cycle parameter plus 1; poll counter is $clog2(MAX_POLLS+1) bits.
- **Parameter limits:** a value of 0 for any *_CYC parameter is illegal (elaboration assertion); minimum is 1.
- **Bus direction:** lcd_data_oe is 0 whenever lcd_rw=1. The top level must gate the write path's DB drive with lcd_data_oe.

Decomposition:
- Shared package lcd_pkg:
  - state enum (IDLE/SETUP/EN_HIGH/EN_LOW/DONE);
  - result bit positions (DATA_LSB=0, DATA_MSB=7, TIMEOUT_BIT=8);
  - operand bit positions (OP_RS=0, OP_POLL=1);
  - BUSY_BIT=7.
- One sub-module, lcd_phase_timer: a loadable down-counter with a terminal-count flag, reused for all three phases.

Test Plan:
- **Data read:** reset, start with dataa=1 and lcd_data_in=8'hA5 → lcd_rs=1, lcd_rw=1, lcd_data_oe=0; lcd_en high for exactly 13 cycles starting 3 cycles after start; done at cycle 29; result=32'h000000A5; afterwards rw=0 and oe=1.
- **Status read, no poll:** dataa=0, bus=8'h8C → single E pulse, result=32'h0000008C, result[8]=0.
- **Poll clears:** dataa=2, bus=8'h80 for the first 3 pulses then 8'h05 → 4 E pulses, done at cycle 4×29=116, result=32'h00000005.
- **Poll timeout:** MAX_POLLS=4, bus stuck at 8'hFF → exactly 4 E pulses, result=32'h000001FF.
- **clk_en stall / reset abort:**
  - clk_en low for 10 cycles mid EN_HIGH → pulse width is 13 enabled cycles, done delayed by 10.
  - reset asserted during EN_LOW → IDLE next cycle, lcd_en=0, no done pulse.
  - start during an active read → ignored; exactly one done pulse.
